// File: rtl/dmem_load_unit.sv
// dmem_load_unit: read-side controller for the 32-bit data memory.
// Takes one load request, issues a word-aligned read, waits out the memory
// read latency, and returns byte/halfword/word data (little-endian) with
// sign or zero extension. Misaligned or unknown load types are rejected
// without touching memory.
module dmem_load_unit #(
   parameter int READ_LATENCY = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        load_req,
   input  logic [2:0]  load_type,
   input  logic [31:0] addr,
   output logic [31:0] mem_addr,
   output logic        mem_read_en,
   input  logic [31:0] mem_read_data,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        addr_error,
   output logic        busy
);

   localparam int DATA_W = 32;

   // Controller states.
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] ISSUE   = 3'd1;
   localparam logic [2:0] WAIT    = 3'd2;
   localparam logic [2:0] CAPTURE = 3'd3;
   localparam logic [2:0] ERROR   = 3'd4;

   // Load type codes (low three bits of the MIPS load opcodes).
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b011;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   // WAIT spans the memory's READ_LATENCY edges; the counter is loaded with
   // READ_LATENCY-1 and the state leaves WAIT on the cycle it reads zero.
   localparam logic [2:0] WAIT_LOAD = 3'(READ_LATENCY - 1);

   logic [2:0] state;
   logic [2:0] waitCnt;
   logic [2:0] typeP0;
   logic [1:0] offP0;

   // Legal type codes with their alignment constraints.
   function automatic logic isLegal(input logic [2:0] t, input logic [1:0] o);
      logic ok;
      case (t)
         LB, LBU: ok = 1'b1;
         LH, LHU: ok = ~o[0];
         LW:      ok = (o == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic [DATA_W-1:0] extendByte(input logic [7:0] b, input logic sgn);
      logic signed [DATA_W-1:0] ext;
      ext = {{24{sgn & b[7]}}, b};
      return ext;
   endfunction

   function automatic logic [DATA_W-1:0] extendHalf(input logic [15:0] h, input logic sgn);
      logic signed [DATA_W-1:0] ext;
      ext = {{16{sgn & h[15]}}, h};
      return ext;
   endfunction

   // Select the addressed lane of the returned word and extend it.
   function automatic logic [DATA_W-1:0] extractLoad(input logic [2:0] t,
                                                     input logic [1:0] o,
                                                     input logic [DATA_W-1:0] word);
      logic [7:0]        laneByte;
      logic [15:0]       laneHalf;
      logic [DATA_W-1:0] res;
      laneByte = word[{o, 3'b000} +: 8];
      laneHalf = o[1] ? word[31:16] : word[15:0];
      case (t)
         LB:      res = extendByte(laneByte, 1'b1);
         LBU:     res = extendByte(laneByte, 1'b0);
         LH:      res = extendHalf(laneHalf, 1'b1);
         LHU:     res = extendHalf(laneHalf, 1'b0);
         default: res = word;
      endcase
      return res;
   endfunction

   assign busy = (state != IDLE);

   // Request capture: type and byte offset are frozen at acceptance so the
   // requester may change addr/load_type while the load is in flight.
   always_ff @(posedge clock) begin
      if (state == IDLE && load_req) begin
         typeP0 <= load_type;
         offP0  <= addr[1:0];
      end
   end

   // Control FSM with registered memory-side and result-side outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         waitCnt     <= 3'd0;
         mem_addr    <= '0;
         mem_read_en <= 1'b0;
         load_data   <= '0;
         load_valid  <= 1'b0;
         addr_error  <= 1'b0;
      end else begin
         mem_read_en <= 1'b0;
         load_valid  <= 1'b0;
         addr_error  <= 1'b0;
         case (state)
            IDLE: begin
               if (load_req) begin
                  if (isLegal(load_type, addr[1:0])) begin
                     mem_addr    <= {addr[31:2], 2'b00};
                     mem_read_en <= 1'b1;
                     state       <= ISSUE;
                  end else begin
                     addr_error  <= 1'b1;
                     state       <= ERROR;
                  end
               end
            end
            ISSUE: begin
               waitCnt <= WAIT_LOAD;
               state   <= WAIT;
            end
            WAIT: begin
               if (waitCnt == 3'd0) begin
                  state <= CAPTURE;
               end else begin
                  waitCnt <= waitCnt - 3'd1;
               end
            end
            CAPTURE: begin
               load_data  <= extractLoad(typeP0, offP0, mem_read_data);
               load_valid <= 1'b1;
               state      <= IDLE;
            end
            ERROR: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_load_unit.sv
// tb_dmem_load_unit: directed bench for dmem_load_unit with a latency-1 and a
// latency-3 instance, each fed by a small delay-line memory model.
module tb_dmem_load_unit;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b011;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        rst1, req1, rdEn1, valid1, err1, busy1;
   logic [2:0]  type1;
   logic [31:0] addr1, memAddr1, rdData1, loadData1;
   logic        rst3, req3, rdEn3, valid3, err3, busy3;
   logic [2:0]  type3;
   logic [31:0] addr3, memAddr3, rdData3, loadData3;

   int nChecks = 0;
   int nErrors = 0;
   int rdCount1 = 0;
   int rdCount3 = 0;

   dmem_load_unit #(.READ_LATENCY(1)) u1 (
      .clock(clock), .reset(rst1), .load_req(req1), .load_type(type1), .addr(addr1),
      .mem_addr(memAddr1), .mem_read_en(rdEn1), .mem_read_data(rdData1),
      .load_data(loadData1), .load_valid(valid1), .addr_error(err1), .busy(busy1));

   dmem_load_unit #(.READ_LATENCY(3)) u3 (
      .clock(clock), .reset(rst3), .load_req(req3), .load_type(type3), .addr(addr3),
      .mem_addr(memAddr3), .mem_read_en(rdEn3), .mem_read_data(rdData3),
      .load_data(loadData3), .load_valid(valid3), .addr_error(err3), .busy(busy3));

   // Memory contents: two known words, a recognisable pattern elsewhere.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      case (a)
         32'h10:  return 32'hABCD1234;
         32'h20:  return 32'h80FF7F01;
         default: return a ^ 32'h5A5A5A5A;
      endcase
   endfunction

   // Memory sampled at edge T presents its word after edge T+READ_LATENCY;
   // otherwise the line carries junk so mistimed captures are visible.
   logic [31:0] s1 [0:1];
   logic [31:0] s3 [0:3];
   always @(posedge clock) begin
      s1[0] <= (rdEn1 === 1'b1) ? memWord(memAddr1) : 32'hDEADBEEF;
      s1[1] <= s1[0];
      s3[0] <= (rdEn3 === 1'b1) ? memWord(memAddr3) : 32'hDEADBEEF;
      s3[1] <= s3[0];
      s3[2] <= s3[1];
      s3[3] <= s3[2];
      if (rdEn1 === 1'b1) rdCount1 <= rdCount1 + 1;
      if (rdEn3 === 1'b1) rdCount3 <= rdCount3 + 1;
   end
   assign rdData1 = s1[1];
   assign rdData3 = s3[3];

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nErrors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic setReq(input int which, input logic r, input logic [2:0] t, input logic [31:0] a);
      if (which == 1) begin
         req1 = r; type1 = t; addr1 = a;
      end else begin
         req3 = r; type3 = t; addr3 = a;
      end
   endtask

   // One complete legal load: checks issue address, latency, data, one read pulse.
   task automatic doLoad(input int which, input logic [2:0] t, input logic [31:0] a,
                         input logic [31:0] exp, input string tag);
      int   lat;
      int   startCnt;
      logic seen;
      lat = (which == 1) ? 3 : 5;
      step();
      setReq(which, 1'b1, t, a);
      step();
      setReq(which, 1'b0, t, a);
      checkVal({tag, ".memaddr"}, (which == 1) ? memAddr1 : memAddr3, {a[31:2], 2'b00});
      checkVal({tag, ".busy"}, 32'((which == 1) ? busy1 : busy3), 32'd1);
      startCnt = (which == 1) ? rdCount1 : rdCount3;
      seen = 1'b0;
      for (int k = 1; k <= 12 && !seen; k++) begin
         step();
         if (((which == 1) ? valid1 : valid3) === 1'b1) begin
            seen = 1'b1;
            checkVal({tag, ".latency"}, 32'(k), 32'(lat));
            checkVal({tag, ".data"}, (which == 1) ? loadData1 : loadData3, exp);
         end
      end
      if (!seen) checkVal({tag, ".timeout"}, 32'd0, 32'd1);
      checkVal({tag, ".rdpulses"}, 32'(((which == 1) ? rdCount1 : rdCount3) - startCnt), 32'd1);
   endtask

   // One rejected request on the latency-1 instance.
   task automatic doErr(input logic [2:0] t, input logic [31:0] a, input string tag);
      logic [31:0] prev;
      int          startCnt;
      prev     = loadData1;
      startCnt = rdCount1;
      step();
      setReq(1, 1'b1, t, a);
      step();
      setReq(1, 1'b0, t, a);
      checkVal({tag, ".err"},   32'(err1),   32'd1);
      checkVal({tag, ".rden"},  32'(rdEn1),  32'd0);
      checkVal({tag, ".valid"}, 32'(valid1), 32'd0);
      step();
      checkVal({tag, ".errpulse"}, 32'(err1),  32'd0);
      checkVal({tag, ".idle"},     32'(busy1), 32'd0);
      checkVal({tag, ".dataheld"}, loadData1,  prev);
      checkVal({tag, ".rdpulses"}, 32'(rdCount1 - startCnt), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   startCnt;
      logic sawValid;

      rst1 = 1'b1; rst3 = 1'b1;
      setReq(1, 1'b0, LW, 32'h0);
      setReq(3, 1'b0, LW, 32'h0);
      step();
      step();
      checkVal("rst.busy",    32'(busy1),  32'd0);
      checkVal("rst.rden",    32'(rdEn1),  32'd0);
      checkVal("rst.memaddr", memAddr1,    32'd0);
      checkVal("rst.data",    loadData1,   32'd0);
      checkVal("rst.valid",   32'(valid1), 32'd0);
      checkVal("rst.err",     32'(err1),   32'd0);
      checkVal("rst3.busy",   32'(busy3),  32'd0);
      rst1 = 1'b0; rst3 = 1'b0;

      // Extraction on the latency-1 instance.
      doLoad(1, LW,  32'h10, 32'hABCD1234, "lw10");
      doLoad(1, LB,  32'h10, 32'h00000034, "lb10");
      doLoad(1, LB,  32'h13, 32'hFFFFFFAB, "lb13");
      doLoad(1, LBU, 32'h13, 32'h000000AB, "lbu13");
      doLoad(1, LH,  32'h12, 32'hFFFFABCD, "lh12");
      doLoad(1, LHU, 32'h12, 32'h0000ABCD, "lhu12");
      doLoad(1, LH,  32'h10, 32'h00001234, "lh10");
      doLoad(1, LB,  32'h21, 32'h0000007F, "lb21");
      doLoad(1, LB,  32'h23, 32'hFFFFFF80, "lb23");
      doLoad(1, LH,  32'h22, 32'hFFFF80FF, "lh22");
      doLoad(1, LHU, 32'h20, 32'h00007F01, "lhu20");
      doLoad(1, LBU, 32'h22, 32'h000000FF, "lbu22");
      doLoad(1, LW,  32'h20, 32'h80FF7F01, "lw20");

      // Rejected requests.
      doErr(LH,     32'h11, "err.lh11");
      doErr(LW,     32'h12, "err.lw12");
      doErr(3'b010, 32'h10, "err.t010");
      doErr(3'b111, 32'h10, "err.t111");

      // Busy: a request during a load is dropped; re-asserted in the
      // load_valid cycle it is accepted.
      startCnt = rdCount1;
      step();
      setReq(1, 1'b1, LW, 32'h10);
      step();
      setReq(1, 1'b1, LBU, 32'h13);
      step();
      setReq(1, 1'b0, LBU, 32'h13);
      checkVal("b2b.busy", 32'(busy1), 32'd1);
      step();
      checkVal("b2b.novalid1", 32'(valid1), 32'd0);
      step();
      checkVal("b2b.valid1", 32'(valid1), 32'd1);
      checkVal("b2b.data1",  loadData1,   32'hABCD1234);
      setReq(1, 1'b1, LBU, 32'h13);
      step();
      setReq(1, 1'b0, LBU, 32'h13);
      checkVal("b2b.accept",  32'(rdEn1),  32'd1);
      checkVal("b2b.validoff", 32'(valid1), 32'd0);
      step();
      checkVal("b2b.wait1", 32'(valid1), 32'd0);
      step();
      checkVal("b2b.wait2", 32'(valid1), 32'd0);
      step();
      checkVal("b2b.valid2", 32'(valid1), 32'd1);
      checkVal("b2b.data2",  loadData1,   32'h000000AB);
      step();
      checkVal("b2b.pulse",    32'(valid1), 32'd0);
      checkVal("b2b.dataheld", loadData1,   32'h000000AB);
      checkVal("b2b.rdpulses", 32'(rdCount1 - startCnt), 32'd2);

      // Latency-3 instance: normal load, then a reset during WAIT.
      doLoad(3, LW, 32'h10, 32'hABCD1234, "u3.lw10");
      step();
      setReq(3, 1'b1, LW, 32'h20);
      step();
      setReq(3, 1'b0, LW, 32'h20);
      step();
      checkVal("u3.abort.busy", 32'(busy3), 32'd1);
      rst3 = 1'b1;
      step();
      rst3 = 1'b0;
      checkVal("u3.abort.idle",    32'(busy3), 32'd0);
      checkVal("u3.abort.data",    loadData3,  32'd0);
      checkVal("u3.abort.rden",    32'(rdEn3), 32'd0);
      checkVal("u3.abort.memaddr", memAddr3,   32'd0);
      sawValid = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (valid3 === 1'b1) sawValid = 1'b1;
      end
      checkVal("u3.abort.novalid", 32'(sawValid), 32'd0);
      doLoad(3, LW, 32'h10, 32'hABCD1234, "u3.after");

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
